mdu_issue_sequencer: RTL and testbench
======================================

Name: mdu_issue_sequencer

Overview:
Issue controller between instruction decode and the execution datapath: ALU, shifter, 32-cycle multiplier and HiLo register.
- Accepts one funct code per valid/ready handshake.
- Drives registered per-unit control codes and the result-mux select.
- Sequences the multi-cycle MULT through to the HiLo write.
- Blocks MULT/MFHI/MFLO while HiLo is in flight; lets single-cycle ALU/shift ops issue alongside a running multiply.

Parameters:
MUL_CYCLES, 32, multiplier iteration count; counter width = $clog2(MUL_CYCLES+1)
HILO_OPEN, 6'b111111, code driven on mul_ctrl to open the HiLo write

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  decode presents an op
funct  input  6  AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MULT=25, MFHI=16, MFLO=18
op_ready  output  1  op accepted this cycle when op_valid&&op_ready
alu_ctrl  output  6  ALU function code (registered)
sht_ctrl  output  6  shifter function code (registered)
mul_ctrl  output  6  multiplier/HiLo control (registered)
mux_sel  output  2  result select: 0 ALU, 1 shifter, 2 HI, 3 LO
res_valid  output  1  single-cycle result on datapath output this cycle
mul_start  output  1  one-cycle pulse, multiplier loads operands
hilo_we  output  1  one-cycle pulse, HiLo captures product
mul_busy  output  1  state != IDLE
illegal  output  1  one-cycle pulse, unsupported funct accepted

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0. All outputs 0 except op_ready, which follows its combinational rule with state=IDLE.
- States: IDLE, MUL_RUN, MUL_WB.
- op_ready (combinational on state and funct):
  - MULT/MFHI/MFLO: 1 only in IDLE.
  - AND/OR/ADD/SUB/SLT/SRL: 1 in IDLE and MUL_RUN; 0 in MUL_WB.
  - Illegal codes: 1 in IDLE only.
- Single-cycle op accepted at edge T; during cycle T+1:
  - ALU ops: alu_ctrl=funct, mux_sel=0, res_valid=1.
  - SRL: sht_ctrl=funct, mux_sel=1, res_valid=1.
  - Otherwise alu_ctrl/sht_ctrl=0 and res_valid=0.
- MFHI/MFLO accepted at T: cycle T+1 has mux_sel=2 or 3 and res_valid=1.
- mux_sel holds its last value when no result is valid.
- MULT accepted at T (IDLE->MUL_RUN):
  - Cycle T+1: mul_start=1, counter=1.
  - Counter increments each cycle in MUL_RUN; mul_ctrl=MULT throughout MUL_RUN.
  - Edge where counter==MUL_CYCLES: ->MUL_WB, counter cleared.
  - Cycle T+MUL_CYCLES+1 (MUL_WB): mul_ctrl=HILO_OPEN, hilo_we=1. Next edge ->IDLE.
  - mul_ctrl=0 outside MUL_RUN/MUL_WB.
- Earliest MFHI/MFLO accept is the first cycle back in IDLE, so the HiLo value is stable.
- Overlap: an ALU/SRL op accepted in MUL_RUN behaves exactly as in IDLE. The multiply counter is unaffected; alu_ctrl/sht_ctrl and mul_ctrl drive independently.
- Illegal funct accepted: illegal=1 next cycle; no control codes, no res_valid, state unchanged.
- op_valid=0: no accept; controls return to 0 the following cycle (except mul_ctrl per state).
- Back-to-back single-cycle ops: one accept per cycle, res_valid continuous.
- Reset mid-multiply: immediate IDLE, counter=0. hilo_we is never asserted for the aborted MULT.
- Only one multiply is ever in flight; no queueing beyond the handshake.

Test Plan:
- Reset release, op_valid=1 funct=32 at edge 0 -> cycle 1: alu_ctrl=32, mux_sel=0, res_valid=1; cycle 2 with op_valid=0: alu_ctrl=0, res_valid=0.
- MULT accepted at edge 0 -> mul_start=1 in cycle 1 only; mul_ctrl=25 in cycles 1..32; cycle 33: mul_ctrl=63, hilo_we=1; cycle 34: mul_busy=0.
- MULT at edge 0, then MFLO held valid -> op_ready=0 in cycles 1..33; accepted at edge 34; cycle 35: mux_sel=3, res_valid=1.
- MULT at edge 0, SRL at edge 5, SUB at edge 6 -> cycle 6: sht_ctrl=2, mux_sel=1; cycle 7: alu_ctrl=34, mux_sel=0; hilo_we still exactly at cycle 33.
- Second MULT presented in cycle 10 of a running multiply -> op_ready=0 until IDLE; accepted at edge 34, mul_start at cycle 35.
- reset=0 asserted asynchronously at cycle 15 of MULT -> outputs 0 immediately, no hilo_we ever; funct=5 after release -> illegal=1 one cycle, res_valid=0.

Source files
------------

// File: rtl/mdu_issue_sequencer.sv
// Issue sequencer for the ALU / shifter / iterative multiplier / HiLo datapath.
// Accepts one funct per handshake, drives registered unit controls and runs MULT through to HiLo write-back.
module mdu_issue_sequencer #(
    parameter int          MUL_CYCLES = 32,
    parameter logic [5:0]  HILO_OPEN  = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [5:0] funct,
    output logic       op_ready,
    output logic [5:0] alu_ctrl,
    output logic [5:0] sht_ctrl,
    output logic [5:0] mul_ctrl,
    output logic [1:0] mux_sel,
    output logic       res_valid,
    output logic       mul_start,
    output logic       hilo_we,
    output logic       mul_busy,
    output logic       illegal
);

    localparam int             CW       = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MUL_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_SLT  = 6'd42;
    localparam logic [5:0] F_SRL  = 6'd2;
    localparam logic [5:0] F_MULT = 6'd25;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MFLO = 6'd18;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_SHT = 2'd1;
    localparam logic [1:0] SEL_HI  = 2'd2;
    localparam logic [1:0] SEL_LO  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        MUL_WB  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_SHT,
        OP_MUL,
        OP_HI,
        OP_LO,
        OP_BAD
    } op_class_t;

    state_t     state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    op_class_t  op_class;
    logic       accept;
    logic [5:0] mul_ctrl_nxt;

    always_comb begin
        unique case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT: op_class = OP_ALU;
            F_SRL:                            op_class = OP_SHT;
            F_MULT:                           op_class = OP_MUL;
            F_MFHI:                           op_class = OP_HI;
            F_MFLO:                           op_class = OP_LO;
            default:                          op_class = OP_BAD;
        endcase
    end

    // Single-cycle ops may slip in beside a running multiply; anything touching HiLo waits for IDLE.
    always_comb begin
        if (op_class == OP_ALU || op_class == OP_SHT) begin
            op_ready = (state == IDLE) || (state == MUL_RUN);
        end else begin
            op_ready = (state == IDLE);
        end
    end

    assign accept = op_valid && op_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        mul_ctrl_nxt = '0;
        unique case (state)
            IDLE: begin
                if (accept && op_class == OP_MUL) begin
                    state_nxt = MUL_RUN;
                    count_nxt = CNT_ONE;
                end
            end
            MUL_RUN: begin
                if (count == CNT_LAST) begin
                    state_nxt = MUL_WB;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            MUL_WB: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        // mul_ctrl is registered, so it is decoded from the state being entered.
        unique case (state_nxt)
            MUL_RUN: mul_ctrl_nxt = F_MULT;
            MUL_WB:  mul_ctrl_nxt = HILO_OPEN;
            default: mul_ctrl_nxt = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_ctrl  <= '0;
            sht_ctrl  <= '0;
            mul_ctrl  <= '0;
            mux_sel   <= SEL_ALU;
            res_valid <= 1'b0;
            mul_start <= 1'b0;
            hilo_we   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            alu_ctrl  <= (accept && op_class == OP_ALU) ? funct : 6'd0;
            sht_ctrl  <= (accept && op_class == OP_SHT) ? funct : 6'd0;
            mul_ctrl  <= mul_ctrl_nxt;
            res_valid <= accept && (op_class == OP_ALU || op_class == OP_SHT ||
                                    op_class == OP_HI  || op_class == OP_LO);
            mul_start <= accept && (op_class == OP_MUL);
            hilo_we   <= (state_nxt == MUL_WB);
            illegal   <= accept && (op_class == OP_BAD);

            // mux_sel only moves when a new result is issued, otherwise it holds.
            if (accept) begin
                unique case (op_class)
                    OP_ALU:  mux_sel <= SEL_ALU;
                    OP_SHT:  mux_sel <= SEL_SHT;
                    OP_HI:   mux_sel <= SEL_HI;
                    OP_LO:   mux_sel <= SEL_LO;
                    default: mux_sel <= mux_sel;
                endcase
            end
        end
    end

    assign mul_busy = (state != IDLE);

endmodule

// File: tb/tb_mdu_issue_sequencer.sv
// Self-checking bench for mdu_issue_sequencer: directed scenarios plus randomized traffic
// checked against a cycle-counting reference model of the issue rules.
module tb_mdu_issue_sequencer;

    localparam int MUL_CYCLES = 32;

    logic       clk;
    logic       reset;
    logic       op_valid;
    logic [5:0] funct;
    logic       op_ready;
    logic [5:0] alu_ctrl, sht_ctrl, mul_ctrl;
    logic [1:0] mux_sel;
    logic       res_valid, mul_start, hilo_we, mul_busy, illegal;

    mdu_issue_sequencer #(.MUL_CYCLES(MUL_CYCLES), .HILO_OPEN(6'b111111)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .funct     (funct),
        .op_ready  (op_ready),
        .alu_ctrl  (alu_ctrl),
        .sht_ctrl  (sht_ctrl),
        .mul_ctrl  (mul_ctrl),
        .mux_sel   (mux_sel),
        .res_valid (res_valid),
        .mul_start (mul_start),
        .hilo_we   (hilo_we),
        .mul_busy  (mul_busy),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Model: cycles elapsed since the MULT accept edge (-1 = no multiply in flight).
    int         since = -1;
    logic       exp_ready, obs_ready, last_acc;
    logic [5:0] e_alu, e_sht, e_mul;
    logic [1:0] e_mux;
    logic       e_resv, e_start, e_we, e_busy, e_ill;

    function automatic bit is_alu(input logic [5:0] f);
        return f == 6'd36 || f == 6'd37 || f == 6'd32 || f == 6'd34 || f == 6'd42;
    endfunction

    function automatic bit is_legal(input logic [5:0] f);
        return is_alu(f) || f == 6'd2 || f == 6'd25 || f == 6'd16 || f == 6'd18;
    endfunction

    // 0 = idle, 1 = multiplier iterating, 2 = HiLo write-back
    function automatic int mode_of(input int s);
        if (s < 0) return 0;
        if (s < MUL_CYCLES) return 1;
        return 2;
    endfunction

    function automatic logic ready_of(input int mode, input logic [5:0] f);
        if (is_alu(f) || f == 6'd2) return mode != 2;
        return mode == 0;
    endfunction

    task automatic model_reset();
        since = -1;
        {e_alu, e_sht, e_mul, e_mux, e_resv, e_start, e_we, e_busy, e_ill} = '0;
    endtask

    // Drive one cycle of stimulus, sample op_ready mid-cycle, advance the model across the edge.
    task automatic tick(input logic v, input logic [5:0] f);
        @(negedge clk);
        op_valid = v;
        funct    = f;
        #1;
        obs_ready = op_ready;
        exp_ready = ready_of(mode_of(since), f);
        @(posedge clk);
        cyc++;
        last_acc = v && exp_ready;
        if (last_acc && f == 6'd25) since = 0;
        else if (since >= 0) begin
            since++;
            if (since > MUL_CYCLES) since = -1;
        end
        e_start = last_acc && f == 6'd25;
        e_mul   = (mode_of(since) == 1) ? 6'd25 : (mode_of(since) == 2) ? 6'd63 : 6'd0;
        e_we    = mode_of(since) == 2;
        e_busy  = mode_of(since) != 0;
        e_alu   = (last_acc && is_alu(f)) ? f : 6'd0;
        e_sht   = (last_acc && f == 6'd2) ? f : 6'd0;
        e_resv  = last_acc && (is_alu(f) || f == 6'd2 || f == 6'd16 || f == 6'd18);
        e_ill   = last_acc && !is_legal(f);
        if (last_acc && is_alu(f)) e_mux = 2'd0;
        else if (last_acc && f == 6'd2) e_mux = 2'd1;
        else if (last_acc && f == 6'd16) e_mux = 2'd2;
        else if (last_acc && f == 6'd18) e_mux = 2'd3;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        op_valid = 1'b0;
        funct    = 6'd0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        funct = 6'd32;
        #1;
        n_total++;
        if ({alu_ctrl, sht_ctrl, mul_ctrl, mux_sel, res_valid, mul_start, hilo_we, mul_busy, illegal} !== '0)
            $display("FAIL reset_outputs: got alu=%0d sht=%0d mul=%0d sel=%0d rv=%b st=%b we=%b busy=%b ill=%b, want all 0",
                     alu_ctrl, sht_ctrl, mul_ctrl, mux_sel, res_valid, mul_start, hilo_we, mul_busy, illegal);
        else n_pass++;
        n_total++;
        if (op_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", op_ready);
        else n_pass++;
    endtask

    task automatic test_alu_basic();
        tick(1'b1, 6'd32);
        n_total++;
        if (alu_ctrl !== 6'd32 || mux_sel !== 2'd0 || res_valid !== 1'b1)
            $display("FAIL add_issue: got alu=%0d sel=%0d rv=%b want 32/0/1", alu_ctrl, mux_sel, res_valid);
        else n_pass++;
        tick(1'b0, 6'd0);
        n_total++;
        if (alu_ctrl !== 6'd0 || res_valid !== 1'b0)
            $display("FAIL add_drain: got alu=%0d rv=%b want 0/0", alu_ctrl, res_valid);
        else n_pass++;
    endtask

    task automatic test_mult();
        int starts = 0, we_at = -1, we_cnt = 0, bad_ctrl = 0;
        tick(1'b1, 6'd25);
        for (int rel = 1; rel <= 34; rel++) begin
            if (mul_start) starts++;
            if (hilo_we) begin we_cnt++; we_at = rel; end
            if (rel <= 32 && mul_ctrl !== 6'd25) bad_ctrl++;
            if (rel == 33 && mul_ctrl !== 6'd63) bad_ctrl++;
            if (rel == 34) begin
                n_total++;
                if (mul_busy !== 1'b0 || mul_ctrl !== 6'd0)
                    $display("FAIL mult_done: got busy=%b mul=%0d want 0/0", mul_busy, mul_ctrl);
                else n_pass++;
            end
            if (rel == 1) begin
                n_total++;
                if (mul_start !== 1'b1) $display("FAIL mult_start: got %b want 1", mul_start);
                else n_pass++;
            end
            if (rel < 34) tick(1'b0, 6'd0);
        end
        n_total++;
        if (starts != 1) $display("FAIL mult_start_count: got %0d want 1", starts);
        else n_pass++;
        n_total++;
        if (we_cnt != 1 || we_at != 33) $display("FAIL mult_hilo_we: got %0d pulses at cycle %0d want 1 at 33", we_cnt, we_at);
        else n_pass++;
        n_total++;
        if (bad_ctrl != 0) $display("FAIL mult_ctrl_seq: got %0d wrong cycles want 0", bad_ctrl);
        else n_pass++;
    endtask

    task automatic test_mflo_wait();
        int stalled = 0, bad_ready = 0;
        bit done = 0;
        tick(1'b1, 6'd25);
        for (int i = 0; i < 50 && !done; i++) begin
            tick(1'b1, 6'd18);
            if (obs_ready !== exp_ready) bad_ready++;
            if (!obs_ready) stalled++;
            if (last_acc) done = 1;
        end
        n_total++;
        if (!done || stalled != 33 || bad_ready != 0)
            $display("FAIL mflo_stall: got accepted=%0d stall=%0d badready=%0d want 1/33/0", done, stalled, bad_ready);
        else n_pass++;
        n_total++;
        if (mux_sel !== 2'd3 || res_valid !== 1'b1)
            $display("FAIL mflo_result: got sel=%0d rv=%b want 3/1", mux_sel, res_valid);
        else n_pass++;
        tick(1'b0, 6'd0);
        n_total++;
        if (mux_sel !== 2'd3 || res_valid !== 1'b0)
            $display("FAIL mux_hold: got sel=%0d rv=%b want 3/0", mux_sel, res_valid);
        else n_pass++;
    endtask

    task automatic test_overlap();
        int c0, we_rel = -1;
        tick(1'b1, 6'd25);
        c0 = cyc;
        for (int i = 0; i < 4; i++) tick(1'b0, 6'd0);
        tick(1'b1, 6'd2);
        n_total++;
        if (sht_ctrl !== 6'd2 || mux_sel !== 2'd1 || res_valid !== 1'b1 || mul_ctrl !== 6'd25)
            $display("FAIL overlap_srl: got sht=%0d sel=%0d rv=%b mul=%0d want 2/1/1/25", sht_ctrl, mux_sel, res_valid, mul_ctrl);
        else n_pass++;
        tick(1'b1, 6'd34);
        n_total++;
        if (alu_ctrl !== 6'd34 || mux_sel !== 2'd0 || sht_ctrl !== 6'd0)
            $display("FAIL overlap_sub: got alu=%0d sel=%0d sht=%0d want 34/0/0", alu_ctrl, mux_sel, sht_ctrl);
        else n_pass++;
        for (int i = 0; i < 30 && we_rel < 0; i++) begin
            tick(1'b0, 6'd0);
            if (hilo_we) we_rel = cyc - c0 + 1;
        end
        n_total++;
        if (we_rel != 33) $display("FAIL overlap_hilo_we: got cycle %0d want 33", we_rel);
        else n_pass++;
        tick(1'b0, 6'd0);
    endtask

    task automatic test_second_mult();
        int stalled = 0;
        bit done = 0;
        tick(1'b1, 6'd25);
        for (int i = 0; i < 9; i++) tick(1'b0, 6'd0);
        for (int i = 0; i < 50 && !done; i++) begin
            tick(1'b1, 6'd25);
            if (!obs_ready) stalled++;
            if (last_acc) done = 1;
        end
        n_total++;
        if (!done || stalled != 24)
            $display("FAIL mult2_stall: got accepted=%0d stall=%0d want 1/24", done, stalled);
        else n_pass++;
        n_total++;
        if (mul_start !== 1'b1 || mul_busy !== 1'b1)
            $display("FAIL mult2_start: got st=%b busy=%b want 1/1", mul_start, mul_busy);
        else n_pass++;
        for (int i = 0; i < 33; i++) tick(1'b0, 6'd0);
    endtask

    task automatic test_reset_mid_mult();
        int we_cnt = 0;
        tick(1'b1, 6'd25);
        for (int i = 0; i < 14; i++) tick(1'b0, 6'd0);
        reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({alu_ctrl, sht_ctrl, mul_ctrl, mux_sel, res_valid, mul_start, hilo_we, mul_busy, illegal} !== '0)
            $display("FAIL async_reset: got mul=%0d busy=%b we=%b want 0/0/0", mul_ctrl, mul_busy, hilo_we);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 6'd0);
            if (hilo_we) we_cnt++;
        end
        n_total++;
        if (we_cnt != 0) $display("FAIL aborted_hilo_we: got %0d pulses want 0", we_cnt);
        else n_pass++;
        tick(1'b1, 6'd5);
        n_total++;
        if (illegal !== 1'b1 || res_valid !== 1'b0 || mul_busy !== 1'b0 || alu_ctrl !== 6'd0)
            $display("FAIL illegal_pulse: got ill=%b rv=%b busy=%b alu=%0d want 1/0/0/0", illegal, res_valid, mul_busy, alu_ctrl);
        else n_pass++;
        tick(1'b0, 6'd0);
        n_total++;
        if (illegal !== 1'b0) $display("FAIL illegal_clear: got %b want 0", illegal);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        logic [5:0] seq [5] = '{6'd36, 6'd37, 6'd2, 6'd42, 6'd34};
        foreach (seq[i]) begin
            tick(1'b1, seq[i]);
            if (res_valid !== 1'b1 || (alu_ctrl | sht_ctrl) !== seq[i]) gaps++;
        end
        n_total++;
        if (gaps != 0) $display("FAIL back_to_back: got %0d bad cycles want 0", gaps);
        else n_pass++;
        tick(1'b0, 6'd0);
    endtask

    task automatic test_random();
        logic [5:0] pool [10] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd16, 6'd18, 6'd0};
        logic [5:0] f;
        for (int i = 0; i < 800; i++) begin
            f = pool[$urandom_range(9)];
            if (f == 6'd0) f = 6'($urandom);
            tick(($urandom_range(3) != 0), f);
            n_total++;
            if (obs_ready !== exp_ready)
                $display("FAIL rand_ready[%0d]: funct=%0d got %b want %b", i, f, obs_ready, exp_ready);
            else n_pass++;
            n_total++;
            if ({alu_ctrl, sht_ctrl, mul_ctrl, mux_sel, res_valid, mul_start, hilo_we, mul_busy, illegal} !==
                {e_alu, e_sht, e_mul, e_mux, e_resv, e_start, e_we, e_busy, e_ill})
                $display("FAIL rand_outputs[%0d]: got alu=%0d sht=%0d mul=%0d sel=%0d rv=%b st=%b we=%b busy=%b ill=%b want %0d %0d %0d %0d %b %b %b %b %b",
                         i, alu_ctrl, sht_ctrl, mul_ctrl, mux_sel, res_valid, mul_start, hilo_we, mul_busy, illegal,
                         e_alu, e_sht, e_mul, e_mux, e_resv, e_start, e_we, e_busy, e_ill);
            else n_pass++;
        end
    endtask

    initial begin
        reset    = 1'b0;
        op_valid = 1'b0;
        funct    = 6'd0;
        model_reset();
        test_reset();
        test_alu_basic();
        test_mult();
        test_mflo_wait();
        test_overlap();
        test_second_mult();
        test_reset_mid_mult();
        test_back_to_back();
        do_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
